mem_port_arbiter: RTL and testbench

Shares one single-port, variable-latency backing memory between the IF-stage instruction fetch port and the MEM-stage data port. It replaces the separate instruction and data memories in the pipeline top. The block accepts at most one outstanding transaction. The data port has priority, and a starvation counter guarantees fetch progress. Per-port grant and response handshakes drive the pipeline stall logic. A fetch kill input discards wrong-path fetch responses after a taken branch or jump.

---
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port, variable-latency memory between the IF fetch port and the
// MEM data port: one transaction in flight, data priority, bounded fetch starvation.
module mem_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  input  logic            if_kill,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [XLEN-1:0] dm_addr,
  input  logic [XLEN-1:0] dm_wdata,
  output logic            dm_gnt,
  output logic            dm_rvalid,
  output logic [XLEN-1:0] dm_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_WAIT} state_e;
  typedef enum logic {OWN_IF, OWN_DM} owner_e;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_e     state_q, state_d;
  owner_e     owner_q, owner_d;
  logic       discard_q, discard_d;
  logic [3:0] starve_q, starve_d;

  logic if_eligible;
  logic pick_dm;
  logic present;
  logic present_dm;

  // Both ports see the memory bus directly; rvalid alone qualifies the data.
  assign if_rdata = mem_rdata;
  assign dm_rdata = mem_rdata;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latches).
    state_d     = state_q;
    owner_d     = owner_q;
    discard_d   = discard_q;
    starve_d    = starve_q;
    if_eligible = if_req && !if_kill;
    pick_dm     = 1'b0;
    present     = 1'b0;
    present_dm  = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    if_gnt      = 1'b0;
    dm_gnt      = 1'b0;
    if_rvalid   = 1'b0;
    dm_rvalid   = 1'b0;

    // No handshakes are offered while reset is held.
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          pick_dm    = dm_req && !(if_eligible && starve_q == STARVE_MAX);
          present    = pick_dm || if_eligible;
          present_dm = pick_dm;
          if (present) begin
            owner_d = pick_dm ? OWN_DM : OWN_IF;
            state_d = mem_ready ? ST_WAIT : ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (owner_q == OWN_IF && if_kill) begin
            state_d = ST_IDLE;
          end else begin
            present    = 1'b1;
            present_dm = (owner_q == OWN_DM);
            if (mem_ready) state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            state_d   = ST_IDLE;
            discard_d = 1'b0;
            if (owner_q == OWN_DM) dm_rvalid = 1'b1;
            else                   if_rvalid = !(discard_q || if_kill);
          end else if (owner_q == OWN_IF && if_kill) begin
            discard_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    mem_req = present;
    if (present) begin
      if (present_dm) begin
        mem_we    = dm_we;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
        dm_gnt    = mem_ready;
      end else begin
        mem_addr  = if_addr;
        if_gnt    = mem_ready;
      end
    end

    // Count data grants that overtook a waiting fetch; any fetch grant or idle fetch port clears it.
    if (if_gnt || !if_req) begin
      starve_d = '0;
    end else if (dm_gnt && starve_q != STARVE_MAX) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_IF;
      discard_q <= 1'b0;
      starve_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      discard_q <= discard_d;
      starve_q  <= starve_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a latency-programmable memory model, a response scoreboard,
// a table of single-cycle arbitration vectors and hand sequences for the multi-cycle cases.
module tb_mem_port_arbiter;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_req, if_kill, if_gnt, if_rvalid;
  logic [XLEN-1:0] if_addr, if_rdata;
  logic            dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [XLEN-1:0] dm_addr, dm_wdata, dm_rdata;
  logic            mem_req, mem_we, mem_ready, mem_rvalid;
  logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_dm;
    logic        is_store;
    logic [31:0] data;
  } sb_t;

  typedef struct {
    logic       if_req;
    logic       if_kill;
    logic       dm_req;
    logic       dm_we;
    logic       rdy;
    logic [1:0] sel;  // 0 none, 1 fetch, 2 data
  } vec_t;

  localparam logic [31:0] IF_A = 32'h0000_0010;
  localparam logic [31:0] DM_A = 32'h0000_0100;
  localparam logic [31:0] WD   = 32'hDEAD_BEEF;

  sb_t         sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          lat   = 1;
  int          cnt   = 0;
  bit          pend  = 1'b0;
  logic [31:0] resp_word;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a ^ 32'h5A5A_0000) + 32'h0000_1357;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired, got timeout expected completion", name);
  endtask

  // Mid-cycle sample: scoreboard pops on rvalid, pushes on gnt; memory model accepts requests.
  task automatic mid();
    sb_t e;
    @(negedge clk);
    if (if_rvalid || dm_rvalid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stray_rvalid: got if_rvalid=%0b dm_rvalid=%0b expected none outstanding",
                 if_rvalid, dm_rvalid);
      end else begin
        e = sb.pop_front();
        check_b("rvalid_dm_port", dm_rvalid, e.is_dm);
        check_b("rvalid_if_port", if_rvalid, !e.is_dm);
        if (!e.is_store) check("rdata", e.is_dm ? dm_rdata : if_rdata, e.data);
      end
    end
    if (if_gnt && dm_gnt) begin
      n_cmp++;
      n_bad++;
      $display("FAIL double_gnt: got if_gnt=1 dm_gnt=1 expected at most one");
    end
    if (if_gnt) sb.push_back('{1'b0, 1'b0, mem_fn(if_addr)});
    if (dm_gnt) sb.push_back('{1'b1, dm_we, mem_fn(dm_addr)});
    if (!rst && mem_req && mem_ready && !pend) begin
      pend      = 1'b1;
      cnt       = lat;
      resp_word = mem_fn(mem_addr);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mem_rvalid = 1'b0;
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = resp_word;
        pend       = 1'b0;
      end
    end
  endtask

  task automatic drain();
    int i;
    if_req    = 1'b0;
    dm_req    = 1'b0;
    if_kill   = 1'b0;
    mem_ready = 1'b1;
    #1;
    for (i = 0; i < 50; i++) begin
      if (sb.size() == 0 && !pend && !mem_rvalid && !mem_req) break;
      mid();
      tick();
    end
    if (i == 50) fail_now("drain");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int   grants[$];
    int   exp_order[6];

    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
    exp_order = '{1, 1, 1, 1, 0, 1};

    rst = 1'b1; if_req = 1'b0; if_kill = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // Reset state
    mid();
    check_b("rst_mem_req", mem_req, 1'b0);
    check_b("rst_if_gnt", if_gnt, 1'b0);
    check_b("rst_dm_gnt", dm_gnt, 1'b0);
    check_b("rst_if_rvalid", if_rvalid, 1'b0);
    check_b("rst_dm_rvalid", dm_rvalid, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    tick();
    rst = 1'b0;
    mem_ready = 1'b1;

    // Single-cycle arbitration from IDLE with starve at 0
    lat = 1;
    for (int v = 0; v < 9; v++) begin
      drain();
      if_req = vecs[v].if_req; if_kill = vecs[v].if_kill; if_addr = IF_A;
      dm_req = vecs[v].dm_req; dm_we = vecs[v].dm_we; dm_addr = DM_A; dm_wdata = WD;
      mem_ready = vecs[v].rdy;
      mid();
      check_b($sformatf("v%0d_mem_req", v), mem_req, vecs[v].sel != 2'd0);
      check_b($sformatf("v%0d_if_gnt", v), if_gnt, vecs[v].sel == 2'd1 && vecs[v].rdy);
      check_b($sformatf("v%0d_dm_gnt", v), dm_gnt, vecs[v].sel == 2'd2 && vecs[v].rdy);
      if (vecs[v].sel != 2'd0) begin
        check($sformatf("v%0d_mem_addr", v), mem_addr, vecs[v].sel == 2'd1 ? IF_A : DM_A);
        check_b($sformatf("v%0d_mem_we", v), mem_we, vecs[v].sel == 2'd2 && vecs[v].dm_we);
      end
      if (vecs[v].sel == 2'd2 && vecs[v].dm_we) check($sformatf("v%0d_mem_wdata", v), mem_wdata, WD);
      tick();
    end
    drain();

    // Fetch-only at latency 2: gnt, then rvalid two cycles later, next gnt every 3 cycles
    lat = 2;
    for (int k = 0; k < 3; k++) begin
      if_req = 1'b1; if_addr = 32'(k * 4);
      mid();
      check_b($sformatf("a%0d_if_gnt", k), if_gnt, 1'b1);
      tick();
      if_addr = 32'((k + 1) * 4);
      mid();
      check_b($sformatf("a%0d_wait_gnt", k), if_gnt, 1'b0);
      check_b($sformatf("a%0d_wait_rvalid", k), if_rvalid, 1'b0);
      tick();
      mid();
      check_b($sformatf("a%0d_if_rvalid", k), if_rvalid, 1'b1);
      tick();
    end
    drain();

    // Simultaneous fetch and load: data first, fetch follows the data response
    lat = 1;
    if_req = 1'b1; if_addr = 32'h40; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    mid();
    check_b("b_dm_gnt", dm_gnt, 1'b1);
    check_b("b_if_gnt0", if_gnt, 1'b0);
    tick();
    dm_req = 1'b0;
    mid();
    check_b("b_dm_rvalid", dm_rvalid, 1'b1);
    check_b("b_if_rvalid0", if_rvalid, 1'b0);
    check_b("b_wait_if_gnt", if_gnt, 1'b0);
    tick();
    mid();
    check_b("b_if_gnt", if_gnt, 1'b1);
    tick();
    drain();

    // Starvation: four data grants with fetch pending, then fetch, then data resumes
    if_req = 1'b1; if_addr = 32'h200; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
    for (int c = 0; c < 40 && grants.size() < 6; c++) begin
      mid();
      if (dm_gnt) grants.push_back(1);
      if (if_gnt) grants.push_back(0);
      tick();
      if (grants.size() > 0 && grants[grants.size() - 1] == 1) dm_addr = dm_addr + 32'h4;
      else if (grants.size() > 0) if_addr = if_addr + 32'h4;
    end
    if (grants.size() < 6) fail_now("starve_grants");
    else for (int g = 0; g < 6; g++) check($sformatf("starve_order%0d", g), 32'(grants[g]), 32'(exp_order[g]));
    drain();

    // HOLD: data owner keeps the bus for 3 not-ready cycles while fetch rises
    mem_ready = 1'b0; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h240; if_addr = 32'h44;
    for (int h = 0; h < 3; h++) begin
      mid();
      check_b($sformatf("d%0d_mem_req", h), mem_req, 1'b1);
      check($sformatf("d%0d_mem_addr", h), mem_addr, 32'h240);
      check_b($sformatf("d%0d_no_gnt", h), dm_gnt | if_gnt, 1'b0);
      tick();
      if_req = 1'b1;
    end
    mem_ready = 1'b1;
    mid();
    check_b("d_dm_gnt", dm_gnt, 1'b1);
    check_b("d_if_gnt0", if_gnt, 1'b0);
    check("d_mem_addr", mem_addr, 32'h240);
    tick();
    drain();

    // Kill while WAIT with fetch owner: response swallowed, next fetch normal
    lat = 3;
    if_req = 1'b1; if_addr = 32'h80;
    mid();
    check_b("e_if_gnt", if_gnt, 1'b1);
    tick();
    if_req = 1'b0; if_kill = 1'b1;
    if (sb.size() > 0) void'(sb.pop_back());
    mid();
    check_b("e_kill_rvalid", if_rvalid, 1'b0);
    tick();
    if_kill = 1'b0;
    mid();
    tick();
    mid();
    check_b("e_resp_if_rvalid", if_rvalid, 1'b0);
    tick();
    if_req = 1'b1; if_addr = 32'h84;
    mid();
    check_b("e_next_if_gnt", if_gnt, 1'b1);
    tick();
    drain();

    // Kill while HOLD with fetch owner: request withdrawn
    lat = 1;
    mem_ready = 1'b0; if_req = 1'b1; if_addr = 32'h90;
    mid();
    check_b("e2_hold_mem_req", mem_req, 1'b1);
    tick();
    if_kill = 1'b1;
    mid();
    check_b("e2_kill_if_gnt", if_gnt, 1'b0);
    tick();
    if_kill = 1'b0; if_req = 1'b0;
    mid();
    check_b("e2_mem_req_dropped", mem_req, 1'b0);
    tick();
    drain();

    // Reset during WAIT, then a late response: nothing reported, fresh fetch works
    lat = 3;
    if_req = 1'b1; if_addr = 32'hC0;
    mid();
    check_b("f_if_gnt", if_gnt, 1'b1);
    tick();
    if_req = 1'b0; rst = 1'b1;
    mid();
    check_b("f_rst_mem_req", mem_req, 1'b0);
    check_b("f_rst_if_rvalid", if_rvalid, 1'b0);
    tick();
    rst = 1'b0;
    sb.delete();
    mid();
    tick();
    mid();
    check_b("f_late_if_rvalid", if_rvalid, 1'b0);
    check_b("f_late_dm_rvalid", dm_rvalid, 1'b0);
    check_b("f_late_mem_req", mem_req, 1'b0);
    check_b("f_late_gnt", if_gnt | dm_gnt, 1'b0);
    tick();
    if_req = 1'b1; if_addr = 32'hC4;
    mid();
    check_b("f_fresh_if_gnt", if_gnt, 1'b1);
    tick();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
